// File: rtl/font_glyph_unit.sv
// font_glyph_unit: glyph-row block RAM with a valid/ready request port and an MSB-first pixel serializer.
// Optional macro FONT_DOUBLE_WIDTH_EN adds reqDouble, which holds every pixel for two clocks.
module font_glyph_unit #(
   parameter int unsigned  GLYPH_W    = 8,
   parameter int unsigned  GLYPH_H    = 16,
   parameter int unsigned  NUM_GLYPHS = 256,
   parameter string        INIT_FILE  = "init_font.hex",
   localparam int unsigned CODE_W     = $clog2(NUM_GLYPHS),
   localparam int unsigned ROW_W      = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1,
   localparam int unsigned ADDR_W     = $clog2(NUM_GLYPHS * GLYPH_H)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wrEn,
   input  logic [ADDR_W-1:0]  wrAddr,
   input  logic [GLYPH_W-1:0] wrData,
   input  logic               reqValid,
   output logic               reqReady,
   input  logic [CODE_W-1:0]  reqGlyph,
   input  logic [ROW_W-1:0]   reqRow,
   input  logic               reqInvert,
`ifdef FONT_DOUBLE_WIDTH_EN
   input  logic               reqDouble,
`endif
   output logic               pixValid,
   output logic               pixOut,
   output logic               pixLast
);

   localparam int unsigned      DEPTH    = NUM_GLYPHS * GLYPH_H;
   localparam int unsigned      CNT_W    = $clog2(GLYPH_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLYPH_W - 1);
   localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ROW_W:0]   H_L      = (ROW_W + 1)'(GLYPH_H);

   typedef enum logic {S_IDLE, S_SHIFT} state_e;

   logic               req_dbl;
`ifdef FONT_DOUBLE_WIDTH_EN
   assign req_dbl = reqDouble;
`else
   assign req_dbl = 1'b0;
`endif

   logic               accept, req_oor;
   logic [ADDR_W-1:0]  req_addr;
   logic [GLYPH_W-1:0] mem [DEPTH];
   logic [GLYPH_W-1:0] rd_q;

   state_e             state_q, state_d;
   logic               s1_q, s1_d, s2_q, s2_d;
   logic               inv_q, inv_d, oor_q, oor_d, dbl1_q, dbl1_d;
   logic [GLYPH_W-1:0] fetch_q, fetch_d, nbuf_q, nbuf_d, sh_q, sh_d;
   logic               fdbl_q, fdbl_d, nv_q, nv_d, ndbl_q, ndbl_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               half_q, half_d, sdbl_q, sdbl_d;
   logic               pix_end, row_end, can_load, load_buf, load_fetch;

   assign accept = reqValid && reqReady;

   always_comb begin
      req_oor  = ({1'b0, reqRow} >= H_L);
      req_addr = '0;
      if (!req_oor)
         req_addr = ADDR_W'(reqGlyph) * ADDR_W'(GLYPH_H) + ADDR_W'(reqRow);
   end

   // Read is sampled on the accept edge, so a same-edge write is seen only by later reads.
   always_ff @(posedge clk) begin
      if (accept)
         rd_q <= mem[req_addr];
      if (wrEn && ({1'b0, wrAddr} < DEPTH_L))
         mem[wrAddr] <= wrData;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         inv_q   <= 1'b0;
         oor_q   <= 1'b0;
         dbl1_q  <= 1'b0;
         fetch_q <= '0;
         fdbl_q  <= 1'b0;
         nv_q    <= 1'b0;
         nbuf_q  <= '0;
         ndbl_q  <= 1'b0;
         sh_q    <= '0;
         cnt_q   <= '0;
         half_q  <= 1'b0;
         sdbl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         inv_q   <= inv_d;
         oor_q   <= oor_d;
         dbl1_q  <= dbl1_d;
         fetch_q <= fetch_d;
         fdbl_q  <= fdbl_d;
         nv_q    <= nv_d;
         nbuf_q  <= nbuf_d;
         ndbl_q  <= ndbl_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         sdbl_q  <= sdbl_d;
      end
   end

   always_comb begin
      pix_end    = !sdbl_q || half_q;
      row_end    = (state_q == S_SHIFT) && (cnt_q == CNT_LAST) && pix_end;
      can_load   = (state_q == S_IDLE) || row_end;
      load_buf   = can_load && nv_q;
      load_fetch = can_load && s2_q && !nv_q;

      state_d = state_q;
      s1_d    = accept;
      s2_d    = s1_q;
      inv_d   = inv_q;
      oor_d   = oor_q;
      dbl1_d  = dbl1_q;
      fetch_d = fetch_q;
      fdbl_d  = fdbl_q;
      nv_d    = nv_q;
      nbuf_d  = nbuf_q;
      ndbl_d  = ndbl_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      half_d  = half_q;
      sdbl_d  = sdbl_q;

      if (accept) begin
         inv_d  = reqInvert;
         oor_d  = req_oor;
         dbl1_d = req_dbl;
      end
      if (s1_q) begin
         fetch_d = (oor_q ? '0 : rd_q) ^ {GLYPH_W{inv_q}};
         fdbl_d  = dbl1_q;
      end

      // Buffered row takes priority; a fresh fetch only bypasses into the shifter when the buffer is empty.
      if (load_buf) begin
         sh_d   = nbuf_q;
         sdbl_d = ndbl_q;
         cnt_d  = '0;
         half_d = 1'b0;
         nv_d   = 1'b0;
      end else if (load_fetch) begin
         sh_d   = fetch_q;
         sdbl_d = fdbl_q;
         cnt_d  = '0;
         half_d = 1'b0;
      end else if (state_q == S_SHIFT) begin
         if (pix_end) begin
            sh_d   = {sh_q[GLYPH_W-2:0], 1'b0};
            cnt_d  = row_end ? '0 : cnt_q + CNT_W'(1);
            half_d = 1'b0;
         end else begin
            half_d = 1'b1;
         end
      end

      if (s2_q && !load_fetch) begin
         nv_d   = 1'b1;
         nbuf_d = fetch_q;
         ndbl_d = fdbl_q;
      end

      case (state_q)
         S_IDLE:  if (load_buf || load_fetch) state_d = S_SHIFT;
         S_SHIFT: if (row_end && !load_buf && !load_fetch) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      reqReady = !s1_q && !s2_q && !nv_q;
      pixValid = (state_q == S_SHIFT);
      pixOut   = (state_q == S_SHIFT) && sh_q[GLYPH_W-1];
      pixLast  = row_end;
   end

endmodule

// File: tb/tb_font_glyph_unit.sv
// Scoreboard bench for font_glyph_unit: a row-level reference model queues expected pixels at each
// accept; an independent monitor pops and compares every live pixel. GLYPH_H=12 makes rows 12..15 out of range.
module tb_font_glyph_unit;
   localparam int W     = 8;
   localparam int H     = 12;
   localparam int G     = 256;
   localparam int DEPTH = G * H;
   localparam int AW    = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wrEn = 1'b0;
   logic [AW-1:0] wrAddr = '0;
   logic [W-1:0]  wrData = '0;
   logic          reqValid = 1'b0;
   logic          reqReady;
   logic [7:0]    reqGlyph = '0;
   logic [3:0]    reqRow = '0;
   logic          reqInvert = 1'b0;
`ifdef FONT_DOUBLE_WIDTH_EN
   logic          reqDouble = 1'b0;
`endif
   logic          pixValid, pixOut, pixLast;

   font_glyph_unit #(
      .GLYPH_W(W), .GLYPH_H(H), .NUM_GLYPHS(G), .INIT_FILE("")
   ) dut (
      .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
      .reqValid(reqValid), .reqReady(reqReady), .reqGlyph(reqGlyph),
      .reqRow(reqRow), .reqInvert(reqInvert),
`ifdef FONT_DOUBLE_WIDTH_EN
      .reqDouble(reqDouble),
`endif
      .pixValid(pixValid), .pixOut(pixOut), .pixLast(pixLast)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic pix; logic last; } pix_t;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] mdl [DEPTH];
   pix_t       exp_q [$];

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: event did not occur within bound (t=%0t)", name, $time);
   endtask

   // Reference: a row is the stored byte (zero if row out of range), optionally inverted, sent MSB first.
   task automatic push_row(input int g, input int r, input bit inv, input bit dbl);
      logic [7:0] row;
      int reps;
      row  = (r >= H) ? 8'h00 : mdl[g * H + r];
      if (inv) row = ~row;
      reps = dbl ? 2 : 1;
      for (int i = W - 1; i >= 0; i--)
         for (int k = 0; k < reps; k++)
            exp_q.push_back(pix_t'{pix: row[i], last: (i == 0 && k == reps - 1)});
   endtask

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic req(input int g, input int r, input bit inv, input bit dbl);
      int t;
      t = 0;
      reqValid  = 1'b1;
      reqGlyph  = 8'(g);
      reqRow    = 4'(r);
      reqInvert = inv;
`ifdef FONT_DOUBLE_WIDTH_EN
      reqDouble = dbl;
`endif
      while (!reqReady && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!reqReady) begin
         fail_now("req_accept_timeout");
         reqValid = 1'b0;
      end else begin
         push_row(g, r, inv, dbl);
         @(negedge clk);
         reqValid = 1'b0;
         chk("ready_low_after_accept", reqReady, 0);
      end
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      wrEn   = 1'b1;
      wrAddr = AW'(a);
      wrData = d;
      @(negedge clk);
      wrEn   = 1'b0;
      mdl[a] = d;
   endtask

   always @(negedge clk) begin
      pix_t e;
      if (!rst && pixValid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pixel: pixOut=%0d pixLast=%0d, expected no pixel (t=%0t)",
                     pixOut, pixLast, $time);
         end else begin
            e = exp_q.pop_front();
            chk("pixOut", pixOut, e.pix);
            chk("pixLast", pixLast, e.last);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      logic [63:0] mask;
      int run;

      repeat (3) @(negedge clk);
      chk("rst_pixValid", pixValid, 0);
      chk("rst_pixOut", pixOut, 0);
      chk("rst_pixLast", pixLast, 0);
      chk("rst_reqReady", reqReady, 1);
      rst = 1'b0;

      for (int a = 0; a < DEPTH; a++) begin
         wrEn   = 1'b1;
         wrAddr = AW'(a);
         wrData = 8'($urandom);
         mdl[a] = wrData;
         @(negedge clk);
      end
      wrEn = 1'b0;
      @(negedge clk);

      // Single request and latency
      wr(65 * H + 3, 8'hA5);
      req(65, 3, 1'b0, 1'b0);
      chk("lat_after_e0", pixValid, 0);
      @(negedge clk);
      chk("lat_after_e1", pixValid, 0);
      @(negedge clk);
      chk("lat_after_e2", pixValid, 1);
      repeat (8) @(negedge clk);
      chk("idle_after_row", pixValid, 0);
      repeat (3) @(negedge clk);

      // Back-to-back stream of four rows: no gap, pixLast every 8th pixel
      fork
         begin
            for (int n = 0; n < 4; n++)
               req($urandom_range(0, G - 1), $urandom_range(0, H - 1), 1'($urandom), 1'b0);
         end
         begin
            t = 0;
            while (!pixValid && t < 10) begin
               @(negedge clk);
               t++;
            end
            run  = 0;
            mask = '0;
            while (pixValid && run < 40) begin
               if (pixLast) mask[run] = 1'b1;
               run++;
               @(negedge clk);
            end
            chk("stream_length", run, 32);
            chk("stream_last_mask", mask, 64'h8080_8080);
         end
      join
      repeat (4) @(negedge clk);

      // Out-of-range row with invert
      req($urandom_range(0, G - 1), 14, 1'b1, 1'b0);
      repeat (12) @(negedge clk);

      // Same-cycle write and read of one address: old data streams, new data on next read
      wr(100 * H + 5, 8'h00);
      wrEn   = 1'b1;
      wrAddr = AW'(100 * H + 5);
      wrData = 8'hFF;
      req(100, 5, 1'b0, 1'b0);
      wrEn = 1'b0;
      mdl[100 * H + 5] = 8'hFF;
      repeat (12) @(negedge clk);
      req(100, 5, 1'b0, 1'b0);
      repeat (12) @(negedge clk);

      // Asynchronous reset during the 4th pixel with a second row buffered
      req($urandom_range(0, G - 1), $urandom_range(0, H - 1), 1'b0, 1'b0);
      req($urandom_range(0, G - 1), $urandom_range(0, H - 1), 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      #1;
      chk("midrow_rst_pixValid", pixValid, 0);
      chk("midrow_rst_pixOut", pixOut, 0);
      chk("midrow_rst_pixLast", pixLast, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("post_rst_reqReady", reqReady, 1);
      repeat (20) @(negedge clk);

`ifdef FONT_DOUBLE_WIDTH_EN
      wr(7 * H, 8'hC0);
      req(7, 0, 1'b0, 1'b1);
      repeat (24) @(negedge clk);
`endif

      // Randomized traffic: occasional writes, random gaps, rows in and out of range
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) == 0)
            wr($urandom_range(0, DEPTH - 1), 8'($urandom));
`ifdef FONT_DOUBLE_WIDTH_EN
         req($urandom_range(0, G - 1), $urandom_range(0, 15), 1'($urandom), 1'($urandom));
`else
         req($urandom_range(0, G - 1), $urandom_range(0, 15), 1'($urandom), 1'b0);
`endif
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("queue_drained", exp_q.size(), 0);
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
